// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing an auto-incrementing 8-bit register bank
module i2c_target_regs #(
   parameter logic [6:0] I2C_ADDR = 7'h50,
   parameter int         ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);
   localparam int N_REGS = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        bit_cnt, bit_cnt_nxt;
   logic [7:0]        shift, shift_nxt;
   logic [ADDR_W-1:0] pointer, pointer_nxt;
   logic              first_byte, first_nxt;
   logic              rw_bit, rw_nxt;
   logic              sda_oe_nxt, busy_nxt, wr_strobe_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [7:0]        wr_data_nxt;
   logic              reg_we;
   logic [7:0]        regs [N_REGS];

   logic scl_meta, scl_s, scl_d;
   logic sda_meta, sda_s, sda_d;
   logic scl_rise, scl_fall, start_cond, stop_cond;

   // two-flop synchronizers plus a previous-value flop; idle bus level is high
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         scl_meta <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
         sda_meta <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
      end else begin
         scl_meta <= scl_in; scl_s <= scl_meta; scl_d <= scl_s;
         sda_meta <= sda_in; sda_s <= sda_meta; sda_d <= sda_s;
      end
   end

   assign scl_rise   = scl_s & ~scl_d;
   assign scl_fall   = ~scl_s & scl_d;
   assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

   // protocol state and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shift      <= 8'h00;
         pointer    <= '0;
         first_byte <= 1'b0;
         rw_bit     <= 1'b0;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         pointer    <= pointer_nxt;
         first_byte <= first_nxt;
         rw_bit     <= rw_nxt;
         sda_oe     <= sda_oe_nxt;
         busy       <= busy_nxt;
         wr_strobe  <= wr_strobe_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
      end
   end

   // next-state logic; START/STOP override any bit event in the same cycle
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      pointer_nxt   = pointer;
      first_nxt     = first_byte;
      rw_nxt        = rw_bit;
      sda_oe_nxt    = sda_oe;
      busy_nxt      = busy;
      wr_strobe_nxt = 1'b0;
      wr_addr_nxt   = wr_addr;
      wr_data_nxt   = wr_data;
      reg_we        = 1'b0;
      if (start_cond) begin
         state_nxt   = ADDR;
         bit_cnt_nxt = 4'd0;
         sda_oe_nxt  = 1'b0;
         busy_nxt    = 1'b0;
      end else if (stop_cond) begin
         state_nxt  = IDLE;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, WR_BYTE: begin
               if (scl_rise && bit_cnt != 4'd8) begin
                  shift_nxt   = {shift[6:0], sda_s};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_nxt = 4'd0;
                  if (state == ADDR) begin
                     if (shift[7:1] == I2C_ADDR) begin
                        sda_oe_nxt = 1'b1;
                        busy_nxt   = 1'b1;
                        rw_nxt     = shift[0];
                        state_nxt  = ADDR_ACK;
                     end else begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WAIT_STOP;
                     end
                  end else begin
                     sda_oe_nxt = 1'b1;
                     state_nxt  = WR_ACK;
                     if (first_byte) begin
                        pointer_nxt = shift[ADDR_W-1:0];
                        first_nxt   = 1'b0;
                     end else begin
                        reg_we        = 1'b1;
                        wr_strobe_nxt = 1'b1;
                        wr_addr_nxt   = pointer;
                        wr_data_nxt   = shift;
                        pointer_nxt   = pointer + 1'b1;
                     end
                  end
               end
            end
            ADDR_ACK, RD_ACK: begin
               if (state == RD_ACK && scl_rise && sda_s) begin
                  state_nxt = WAIT_STOP;
                  busy_nxt  = 1'b0;
               end else if (scl_fall) begin
                  bit_cnt_nxt = 4'd0;
                  if (state == ADDR_ACK && !rw_bit) begin
                     sda_oe_nxt = 1'b0;
                     first_nxt  = 1'b1;
                     state_nxt  = WR_BYTE;
                  end else begin
                     // latch the outgoing byte now so later writes cannot alter it
                     shift_nxt   = regs[pointer];
                     sda_oe_nxt  = ~regs[pointer][7];
                     pointer_nxt = pointer + 1'b1;
                     state_nxt   = RD_BYTE;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_nxt  = 1'b0;
                  bit_cnt_nxt = 4'd0;
                  state_nxt   = WR_BYTE;
               end
            end
            RD_BYTE: begin
               if (scl_rise && bit_cnt != 4'd8) begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  sda_oe_nxt  = 1'b0;
                  bit_cnt_nxt = 4'd0;
                  state_nxt   = RD_ACK;
               end else if (scl_fall && bit_cnt != 4'd0) begin
                  shift_nxt  = {shift[6:0], 1'b0};
                  sda_oe_nxt = ~shift[6];
               end
            end
            WAIT_STOP: sda_oe_nxt = 1'b0;
            default: begin
               state_nxt  = IDLE;
               sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   // register bank, written only by completed bus data bytes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_REGS; i++) regs[i] <= 8'h00;
      end else if (reg_we) begin
         regs[pointer] <= shift;
      end
   end

   // registered local read port; a same-cycle bus write shows up one cycle later
   always_ff @(posedge clk) begin
      if (!reset_n) rd_data <= 8'h00;
      else          rd_data <= regs[rd_addr];
   end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - randomized self-checking bench for i2c_target_regs
module tb_i2c_target_regs;
   localparam int Q = 6;
   localparam logic [7:0] ADDR_WR = 8'hA0;
   localparam logic [7:0] ADDR_RD = 8'hA1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       scl_m = 1'b1, sda_m = 1'b1, sda_override = 1'b0;
   logic       scl_in, sda_in, sda_oe, wr_strobe, busy;
   logic [3:0] rd_addr = 4'd0, wr_addr;
   logic [7:0] rd_data, wr_data;

   assign scl_in = scl_m;
   assign sda_in = sda_override ? sda_m : (sda_m & ~sda_oe);

   i2c_target_regs dut (
      .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_errors = 0;
   logic [7:0]  model_regs [16];
   int          model_ptr = 0;
   logic [11:0] strobe_q[$], exp_q[$];
   logic [7:0]  wbytes[$], rbytes[$];
   logic        saw_oe = 1'b0, saw_busy = 1'b0;
   logic [3:0]  last_wr_addr = 4'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_strobe) begin
         strobe_q.push_back({wr_addr, wr_data});
         last_wr_addr = wr_addr;
      end
      if (sda_oe) saw_oe = 1'b1;
      if (busy)   saw_busy = 1'b1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      sda_m = 1'b0; wait_clks(Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      sda_m = 1'b1; wait_clks(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_clks(Q);
      scl_m = 1'b1; wait_clks(2 * Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      b = sda_in;   wait_clks(Q);
      scl_m = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      acked = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic send_ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~send_ack);
   endtask

   task automatic local_read(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk) rd_addr = a;
      @(negedge clk) d = rd_data;
   endtask

   task automatic check_strobes(input string tag);
      check_eq({tag, "_strobe_cnt"}, strobe_q.size(), exp_q.size());
      while (exp_q.size() > 0 && strobe_q.size() > 0)
         check_eq({tag, "_strobe"}, strobe_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      strobe_q.delete();
   endtask

   task automatic bus_write_txn(input logic [7:0] ptr, input string tag);
      logic ack;
      logic [3:0] a;
      bus_start();
      write_byte(ADDR_WR, ack); check_eq({tag, "_addr_ack"}, ack, 1);
      write_byte(ptr, ack);     check_eq({tag, "_ptr_ack"}, ack, 1);
      model_ptr = ptr % 16;
      foreach (wbytes[i]) begin
         write_byte(wbytes[i], ack);
         check_eq({tag, "_data_ack"}, ack, 1);
         a = 4'(model_ptr);
         model_regs[model_ptr] = wbytes[i];
         exp_q.push_back({a, wbytes[i]});
         model_ptr = (model_ptr + 1) % 16;
      end
      bus_stop();
      check_strobes(tag);
   endtask

   task automatic bus_read_txn(input logic set_ptr, input logic [7:0] ptr, input int n, input string tag);
      logic ack;
      logic [7:0] d;
      rbytes.delete();
      bus_start();
      if (set_ptr) begin
         write_byte(ADDR_WR, ack); check_eq({tag, "_waddr_ack"}, ack, 1);
         write_byte(ptr, ack);     check_eq({tag, "_ptr_ack"}, ack, 1);
         model_ptr = ptr % 16;
         bus_start();
      end
      write_byte(ADDR_RD, ack); check_eq({tag, "_raddr_ack"}, ack, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, i != n - 1);
         rbytes.push_back(d);
         check_eq({tag, "_rdata"}, d, model_regs[model_ptr]);
         model_ptr = (model_ptr + 1) % 16;
      end
      check_eq({tag, "_nack_sda_oe"}, sda_oe, 0);
      check_eq({tag, "_nack_busy"}, busy, 0);
      bus_stop();
      check_strobes(tag);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic       ack;
      int         waited;
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

      // reset state
      wait_clks(4);
      check_eq("rst_sda_oe", sda_oe, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_wr_strobe", wr_strobe, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_rd_data", rd_data, 0);
      reset_n = 1'b1;
      wait_clks(4);

      // directed write: pointer 3, data 0x11 0x22
      wbytes = '{8'h11, 8'h22};
      bus_write_txn(8'h03, "wr");
      local_read(4'd4, d);
      check_eq("wr_rd4", d, 8'h22);

      // combined read with repeated START
      bus_read_txn(1'b1, 8'h03, 2, "cmb");
      check_eq("cmb_byte0", rbytes[0], 8'h11);
      check_eq("cmb_byte1", rbytes[1], 8'h22);

      // address mismatch
      saw_oe = 1'b0; saw_busy = 1'b0;
      bus_start();
      write_byte(8'hA2, ack); check_eq("mis_addr_ack", ack, 0);
      write_byte(8'h55, ack); check_eq("mis_data_ack", ack, 0);
      bus_stop();
      check_eq("mis_saw_oe", saw_oe, 0);
      check_eq("mis_saw_busy", saw_busy, 0);
      check_strobes("mis");

      // pointer wrap
      wbytes = '{8'hAA, 8'hBB};
      bus_write_txn(8'h0F, "wrap");
      check_eq("wrap_last_wr_addr", last_wr_addr, 0);
      local_read(4'd15, d); check_eq("wrap_reg15", d, 8'hAA);
      local_read(4'd0, d);  check_eq("wrap_reg0", d, 8'hBB);

      // randomized transactions against the reference model
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            wbytes.delete();
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) wbytes.push_back(8'($urandom));
            bus_write_txn(8'($urandom), "rnd_wr");
         end else begin
            bus_read_txn(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 5)), "rnd_rd");
         end
      end

      // START after 4 bits of a data byte: no write, new address decoded
      bus_start();
      write_byte(ADDR_WR, ack); check_eq("mid_addr_ack", ack, 1);
      write_byte(8'h05, ack);   check_eq("mid_ptr_ack", ack, 1);
      model_ptr = 5;
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      bus_start();
      write_byte(ADDR_RD, ack); check_eq("mid_raddr_ack", ack, 1);
      read_byte(d, 1'b0);
      check_eq("mid_rdata", d, model_regs[5]);
      model_ptr = 6;
      bus_stop();
      check_strobes("mid");

      // STOP while the target drives a 0 data bit
      wbytes = '{8'h3C};
      bus_write_txn(8'h09, "pre_stop");
      bus_start();
      write_byte(ADDR_WR, ack);
      write_byte(8'h09, ack);
      bus_start();
      write_byte(ADDR_RD, ack); check_eq("rdstop_raddr_ack", ack, 1);
      check_eq("rdstop_driving0", sda_oe, 1);
      model_ptr = 10;
      sda_override = 1'b1;
      sda_m = 1'b0; wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      sda_m = 1'b1;
      waited = 0;
      while (sda_oe && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      check_eq("rdstop_release", sda_oe, 0);
      check_eq("rdstop_within4", waited <= 4, 1);
      check_eq("rdstop_busy", busy, 0);
      sda_override = 1'b0;
      wait_clks(Q);

      // reset asserted while ACKing the address byte
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(ADDR_WR[i]);
      sda_m = 1'b1;
      waited = 0;
      while (!sda_oe && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check_eq("rst_ack_seen", sda_oe, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_release_sda", sda_oe, 0);
      scl_m = 1'b1; sda_m = 1'b1;
      wait_clks(3);
      check_eq("rst2_busy", busy, 0);
      check_eq("rst2_rd_data", rd_data, 0);
      check_eq("rst2_pointer", dut.pointer, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
      model_ptr = 0;
      wait_clks(4);
      for (int i = 0; i < 16; i++) begin
         local_read(4'(i), d);
         check_eq("rst2_reg", d, 8'h00);
      end

      // post-reset traffic and final bank sweep
      wbytes = '{8'hC3, 8'h5A, 8'h7E};
      bus_write_txn(8'h0E, "post_wr");
      bus_read_txn(1'b1, 8'h0E, 3, "post_rd");
      for (int i = 0; i < 16; i++) begin
         local_read(4'(i), d);
         check_eq("final_reg", d, model_regs[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
